// File: rtl/ifu_pc_gen.sv
// Fetch PC generator: holds the fetch PC, steers it from exception/branch/sequential
// sources, buffers a redirect that arrives under stall, and flags misaligned fetches.
module ifu_pc_gen #(
    parameter int                PC_W        = 32,
    parameter logic [PC_W-1:0]   RESET_PC    = 32'hBFC00000,
    parameter int                N_STALL     = 4,
    parameter int                FETCH_WIDTH = 1,
    parameter logic [31:0]       EXC_ADEL    = 32'h00000010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_STALL-1:0] stall_i,
    input  logic               exc_valid_i,
    input  logic [PC_W-1:0]    exc_pc_i,
    input  logic               tgt_valid_i,
    input  logic [PC_W-1:0]    tgt_pc_i,
    output logic               req_valid_o,
    input  logic               req_ready_i,
    output logic [PC_W-1:0]    req_pc_o,
    output logic [2:0]         req_cnt_o,
    output logic [PC_W-1:0]    pc_plus_o,
    output logic [31:0]        fetch_exc_o,
    output logic               redir_pend_o
);

    localparam int              FB      = 4 * FETCH_WIDTH;
    localparam int              OFF_W   = $clog2(FB);
    localparam logic [PC_W-1:0] FB_MASK = ~(PC_W'(FB - 1));

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic              pend_valid_q, pend_valid_d;

    logic              stall;
    logic              misal;
    logic              adv;

    assign stall        = |stall_i;
    assign misal        = (pc_q[1:0] != 2'b00);
    assign req_valid_o  = (state_q == RUN) & ~stall & ~misal;
    assign adv          = req_valid_o & req_ready_i & ~stall;

    assign req_pc_o     = pc_q;
    assign pc_plus_o    = (pc_q & FB_MASK) + PC_W'(FB);
    assign fetch_exc_o  = misal ? EXC_ADEL : 32'd0;
    assign redir_pend_o = pend_valid_q;

    // Group count shrinks when the PC enters the fetch block past its first slot.
    generate
        if (FETCH_WIDTH == 1) begin : g_cnt_single
            assign req_cnt_o = 3'd1;
        end else begin : g_cnt_multi
            assign req_cnt_o = 3'(FETCH_WIDTH) - 3'(pc_q[OFF_W-1:2]);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (misal) state_d = ERR;
            default: state_d = state_q;
        endcase

        if (exc_valid_i) begin
            pc_d         = exc_pc_i;
            pend_valid_d = 1'b0;
            state_d      = RUN;
        end else if (state_q != ERR) begin
            // A redirect kills the outstanding request, so no handshake is required.
            if (tgt_valid_i && !stall) begin
                pc_d         = tgt_pc_i;
                pend_valid_d = 1'b0;
            end else if (tgt_valid_i && stall) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = tgt_pc_i;
            end else if (pend_valid_q && !stall) begin
                pc_d         = pend_pc_q;
                pend_valid_d = 1'b0;
            end else if (adv) begin
                pc_d         = pc_plus_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Scoreboard bench for ifu_pc_gen: expectations are queued while a cycle is driven and
// compared mid-cycle against one FETCH_WIDTH=1 and one FETCH_WIDTH=2 instance.
module tb_ifu_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  stall_i;
    logic        exc_valid_i;
    logic [31:0] exc_pc_i;
    logic        tgt_valid_i;
    logic [31:0] tgt_pc_i;
    logic        req_ready_i;

    logic        req_valid_o,  req_valid2_o;
    logic [31:0] req_pc_o,     req_pc2_o;
    logic [2:0]  req_cnt_o,    req_cnt2_o;
    logic [31:0] pc_plus_o,    pc_plus2_o;
    logic [31:0] fetch_exc_o,  fetch_exc2_o;
    logic        redir_pend_o, redir_pend2_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ifu_pc_gen #(.FETCH_WIDTH(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i),
        .tgt_valid_i(tgt_valid_i), .tgt_pc_i(tgt_pc_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_pc_o(req_pc_o), .req_cnt_o(req_cnt_o), .pc_plus_o(pc_plus_o),
        .fetch_exc_o(fetch_exc_o), .redir_pend_o(redir_pend_o)
    );

    ifu_pc_gen #(.FETCH_WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i),
        .tgt_valid_i(tgt_valid_i), .tgt_pc_i(tgt_pc_i),
        .req_valid_o(req_valid2_o), .req_ready_i(req_ready_i),
        .req_pc_o(req_pc2_o), .req_cnt_o(req_cnt2_o), .pc_plus_o(pc_plus2_o),
        .fetch_exc_o(fetch_exc2_o), .redir_pend_o(redir_pend2_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] observe(input string tag);
        case (tag)
            "pc":    return req_pc_o;
            "vld":   return {31'd0, req_valid_o};
            "pend":  return {31'd0, redir_pend_o};
            "exc":   return fetch_exc_o;
            "cnt":   return {29'd0, req_cnt_o};
            "plus":  return pc_plus_o;
            "pc2":   return req_pc2_o;
            "cnt2":  return {29'd0, req_cnt2_o};
            "plus2": return pc_plus2_o;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    // Compare queued expectations at mid-cycle, then advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.tag), e.val);
        end
        $display("cyc t=%0t pc=%08h vld=%0b pend=%0b exc=%08h pc2=%08h", $time,
                 req_pc_o, req_valid_o, redir_pend_o, fetch_exc_o, req_pc2_o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 4'd0; exc_valid_i = 1'b0; exc_pc_i = 32'd0;
        tgt_valid_i = 1'b0; tgt_pc_i = 32'd0; req_ready_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Boot sequence
        rst_n = 1'b1;
        expect_val("pc", 32'hBFC00000); expect_val("vld", 0); expect_val("pend", 0);
        tick();
        expect_val("pc", 32'hBFC00000); expect_val("vld", 1); expect_val("cnt", 1);
        tick();
        expect_val("pc", 32'hBFC00004); expect_val("plus", 32'hBFC00008); expect_val("exc", 0);
        tick();
        expect_val("pc", 32'hBFC00008); expect_val("vld", 1);
        tick();

        // Redirect buffered under stall
        stall_i = 4'b0100; tgt_valid_i = 1'b1; tgt_pc_i = 32'h80000100;
        expect_val("pc", 32'hBFC0000C); expect_val("vld", 0); expect_val("pend", 0);
        tick();
        tgt_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_val("pc", 32'hBFC0000C); expect_val("pend", 1); expect_val("vld", 0);
            tick();
        end
        stall_i = 4'b0000;
        expect_val("pc", 32'hBFC0000C); expect_val("pend", 1); expect_val("vld", 1);
        tick();
        expect_val("pc", 32'h80000100); expect_val("pend", 0); expect_val("vld", 1);
        tick();

        // Exception beats target while stalled
        stall_i = 4'b0001; exc_valid_i = 1'b1; exc_pc_i = 32'hBFC00380;
        tgt_valid_i = 1'b1; tgt_pc_i = 32'h80001000;
        expect_val("pc", 32'h80000104); expect_val("vld", 0);
        tick();
        exc_valid_i = 1'b0; tgt_valid_i = 1'b0;
        expect_val("pc", 32'hBFC00380); expect_val("pend", 0); expect_val("vld", 0);
        tick();
        stall_i = 4'b0000;
        expect_val("pc", 32'hBFC00380); expect_val("vld", 1);
        tick();

        // Misaligned target enters ERR, exception recovers
        tgt_valid_i = 1'b1; tgt_pc_i = 32'h80000002;
        expect_val("pc", 32'hBFC00384); expect_val("vld", 1);
        tick();
        tgt_valid_i = 1'b0;
        expect_val("pc", 32'h80000002); expect_val("exc", 32'h10); expect_val("vld", 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            tgt_valid_i = (i == 3); tgt_pc_i = 32'h80004000;
            expect_val("pc", 32'h80000002); expect_val("vld", 0);
            expect_val("exc", 32'h10); expect_val("pend", 0);
            tick();
        end
        tgt_valid_i = 1'b0;
        exc_valid_i = 1'b1; exc_pc_i = 32'hBFC00380;
        expect_val("pc", 32'h80000002); expect_val("vld", 0);
        tick();
        exc_valid_i = 1'b0;
        expect_val("pc", 32'hBFC00380); expect_val("vld", 1); expect_val("exc", 0);
        tick();

        // Wider fetch group: partial count and wrap-around
        tgt_valid_i = 1'b1; tgt_pc_i = 32'h80000004;
        tick();
        tgt_valid_i = 1'b0;
        expect_val("pc2", 32'h80000004); expect_val("cnt2", 1); expect_val("plus2", 32'h80000008);
        expect_val("pc", 32'h80000004); expect_val("cnt", 1); expect_val("plus", 32'h80000008);
        tick();
        expect_val("pc2", 32'h80000008); expect_val("cnt2", 2); expect_val("plus2", 32'h80000010);
        expect_val("plus", 32'h8000000C);
        tick();
        tgt_valid_i = 1'b1; tgt_pc_i = 32'hFFFFFFF8;
        tick();
        tgt_valid_i = 1'b0;
        expect_val("pc2", 32'hFFFFFFF8); expect_val("plus2", 32'h00000000); expect_val("cnt2", 2);
        expect_val("pc", 32'hFFFFFFF8); expect_val("plus", 32'hFFFFFFFC);
        tick();
        expect_val("pc2", 32'h00000000);
        expect_val("pc", 32'hFFFFFFFC); expect_val("plus", 32'h00000000);
        tick();
        expect_val("pc", 32'h00000000);
        tick();

        // Reset while a redirect is pending
        stall_i = 4'b0010; tgt_valid_i = 1'b1; tgt_pc_i = 32'h80002000; req_ready_i = 1'b0;
        tick();
        tgt_valid_i = 1'b0;
        expect_val("pend", 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; stall_i = 4'b0000; req_ready_i = 1'b1;
        expect_val("pc", 32'hBFC00000); expect_val("pend", 0); expect_val("vld", 0);
        tick();
        expect_val("pc", 32'hBFC00000); expect_val("vld", 1); expect_val("pend", 0);
        tick();
        expect_val("pc", 32'hBFC00004);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
